// File: rtl/restoring_divider.sv
// Sequential radix-2 restoring divider: 16-bit unsigned dividend / 8-bit unsigned divisor.
// One quotient bit is resolved per clock behind a start/done handshake.
// States:
//   state     | meaning
//   ST_IDLE   | waiting for start, results held
//   ST_CALC   | one restoring iteration per clock, 16 in total
//   ST_FINISH | done pulse cycle, results valid
module restoring_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t      state;
    logic [8:0]  r_reg;
    logic [15:0] q_reg;
    logic [3:0]  cnt;
    logic [7:0]  dvs_reg;

    logic [8:0]  r_shift;
    logic [15:0] q_shift;
    logic [9:0]  trial;
    logic        take;
    logic [8:0]  r_next;
    logic [15:0] q_next;

    // One restoring step: shift {R,Q}, trial-subtract the divisor, keep or restore.
    // R[8] set would mean the shifted value exceeds any 8-bit divisor, so it forces a take.
    always_comb begin
        r_shift = {r_reg[7:0], q_reg[15]};
        q_shift = {q_reg[14:0], 1'b0};
        trial   = {1'b0, r_shift} - {2'b00, dvs_reg};
        take    = ~trial[9] | r_reg[8];
        r_next  = take ? trial[8:0] : r_shift;
        q_next  = {q_shift[15:1], take};
    end

    // Control FSM, iteration registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            r_reg       <= 9'd0;
            q_reg       <= 16'd0;
            cnt         <= 4'd0;
            dvs_reg     <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= 16'd0;
            remainder   <= 8'd0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dvs_reg <= divisor;
                        if (divisor == 8'd0) begin
                            quotient    <= 16'hFFFF;
                            remainder   <= 8'd0;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= ST_FINISH;
                        end else begin
                            r_reg       <= 9'd0;
                            q_reg       <= dividend;
                            cnt         <= 4'd0;
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            state       <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        quotient  <= q_next;
                        remainder <= r_next[7:0];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: arithmetic reference model plus directed vectors.
module tb_restoring_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = 16'd0;
    logic [7:0]  divisor = 8'd0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    restoring_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: one operation in flight, timed by edge number relative to acceptance.
    int          edge_n = 0;
    bit          pend = 1'b0;
    bit          pend_zero = 1'b0;
    int          pend_edge = 0;
    int          done_edge = 0;
    int          free_edge = 0;
    logic [15:0] pq = 16'd0;
    logic [7:0]  pr = 8'd0;
    logic [15:0] lq = 16'd0;
    logic [7:0]  lr = 8'd0;
    logic        ldbz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend = 1'b0;
            lq   = 16'd0;
            lr   = 8'd0;
            ldbz = 1'b0;
        end else begin
            edge_n++;
            if (pend && !pend_zero && edge_n == done_edge) begin
                lq = pq;
                lr = pr;
            end
            if (pend && edge_n >= free_edge) pend = 1'b0;
            if (!pend && start) begin
                pend      = 1'b1;
                pend_edge = edge_n;
                if (divisor == 8'd0) begin
                    pend_zero = 1'b1;
                    done_edge = edge_n;
                    free_edge = edge_n + 2;
                    lq        = 16'hFFFF;
                    lr        = 8'd0;
                    ldbz      = 1'b1;
                end else begin
                    pend_zero = 1'b0;
                    pq        = dividend / {8'd0, divisor};
                    pr        = 8'(dividend % {8'd0, divisor});
                    done_edge = edge_n + 16;
                    free_edge = edge_n + 18;
                    ldbz      = 1'b0;
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        bit exp_done;
        bit exp_busy;
        if (!rst_n) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_quotient", quotient, 0);
            check("rst_remainder", remainder, 0);
            check("rst_dbz", div_by_zero, 0);
        end else begin
            exp_done = pend && (edge_n == done_edge);
            exp_busy = pend && !pend_zero && (edge_n >= pend_edge) && (edge_n < pend_edge + 16);
            check("mdl_done", done, exp_done);
            check("mdl_busy", busy, exp_busy);
            check("busy_and_done", busy & done, 0);
            if (!pend || edge_n >= done_edge) begin
                check("mdl_quotient", quotient, lq);
                check("mdl_remainder", remainder, lr);
                check("mdl_dbz", div_by_zero, ldbz);
            end
        end
    end

    // Issue one division from IDLE, scramble operands after acceptance, wait (bounded) for done.
    task automatic run_core(input logic [15:0] a, input logic [7:0] b,
                            output logic [15:0] q, output logic [7:0] r, output logic dz,
                            output int lat, output int nbusy, output bit seen);
        @(posedge clk); #2;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #2;
        start    = 1'b0;
        dividend = 16'h5A5A;
        divisor  = 8'h33;
        seen  = 1'b0;
        nbusy = 0;
        lat   = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat = i + 1;
            if (busy) nbusy++;
            if (done) seen = 1'b1;
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
    endtask

    task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                           input logic [15:0] eq, input logic [7:0] er, input logic edz,
                           input int elat, input int ebusy);
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          lat;
        int          nbusy;
        bit          seen;
        run_core(a, b, q, r, dz, lat, nbusy, seen);
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_busy_cycles"}, nbusy, ebusy);
        check({tag, "_quotient"}, q, eq);
        check({tag, "_remainder"}, r, er);
        check({tag, "_dbz"}, dz, edz);
    endtask

    initial begin
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          lat;
        int          nbusy;
        bit          seen;
        time         t;
        time         tprev;
        logic [15:0] ra;
        logic [7:0]  rb;

        repeat (3) @(posedge clk);
        #2;
        check("init_quotient", quotient, 0);
        check("init_busy", busy, 0);
        rst_n = 1'b1;

        run_div("d1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17, 16);
        run_div("d65535_255", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 17, 16);
        run_div("d65535_1", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 17, 16);
        run_div("d0_5", 16'd0, 8'd5, 16'd0, 8'd0, 1'b0, 17, 16);
        run_div("d200_201", 16'd200, 8'd201, 16'd0, 8'd200, 1'b0, 17, 16);
        run_div("d1234_0", 16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, 1, 0);
        run_div("d10_3", 16'd10, 8'd3, 16'd3, 8'd1, 1'b0, 17, 16);

        // start held high; operands disturbed mid-calculation
        @(posedge clk); #2;
        dividend = 16'd300;
        divisor  = 8'd9;
        start    = 1'b1;
        tprev    = 0;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            t = $time;
            check("b2b_done_seen", seen, 1);
            check("b2b_quotient", quotient, 33);
            check("b2b_remainder", remainder, 3);
            if (k > 0) check("b2b_period", 32'((t - tprev) / 10), 18);
            tprev = t;
            repeat (5) @(posedge clk);
            #2;
            dividend = 16'd77;
            divisor  = 8'd5;
            repeat (3) @(posedge clk);
            #2;
            dividend = 16'd300;
            divisor  = 8'd9;
        end
        start = 1'b0;
        repeat (20) @(posedge clk);

        // reset in the middle of a calculation
        @(posedge clk); #2;
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_dbz", div_by_zero, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_div("d50_7", 16'd50, 8'd7, 16'd7, 8'd1, 1'b0, 17, 16);

        // random regression on the division invariant
        for (int n = 0; n < 300; n++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 8'($urandom_range(1, 255));
            run_core(ra, rb, q, r, dz, lat, nbusy, seen);
            check("rand_done_seen", seen, 1);
            check("rand_latency", lat, 17);
            check("rand_identity", int'(q) * int'(rb) + int'(r), int'(ra));
            check("rand_rem_lt_div", (r < rb) ? 1 : 0, 1);
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
